fetch_stall_ctrl: RTL
=====================

// Module: fetch_stall_ctrl
// PURPOSE
//   Consumer of the decode-stage stall signals: owns the PC register and the IF/ID pipeline register.
//   Holds PC and/or IF/ID when the hazard unit asserts PCSTOP/IDIF/ControlMux and applies branch/jump redirects from decode.
//   Inserts a bubble into IF/ID on redirect.
//   Keeps saturating stall/flush counters and a consecutive-stall watchdog for debug.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded on Reset
//   NOP_INSTR    32'h0000_0000  encoding written into IF/ID on a flush (sll $0,$0,0)
//   CNT_W        16             width of StallCount/FlushCount (saturating)
//   STALL_LIMIT  8              consecutive stall cycles before StallTimeout sets
// PORTS
//   Clk             in   1   rising-edge clock
//   Reset           in   1   synchronous, active-high
//   PCSTOP          in   1   1 = hold PC this cycle
//   IDIF            in   1   1 = IF/ID may load; 0 = hold IF/ID
//   ControlMux      in   1   1 = decode is bubbling (counted as a stall cycle)
//   BranchTaken     in   1   decode resolved a taken branch/jump
//   BranchTarget    in   32  redirect address, valid with BranchTaken
//   Instruction_IF  in   32  imem read data at PC (combinational)
//   PC              out  32  current fetch address to imem
//   Instruction_ID  out  32  IF/ID instruction register
//   PCPlus4_ID      out  32  IF/ID copy of fetch PC + 4
//   Valid_ID        out  1   0 = IF/ID holds an inserted bubble
//   StallCount      out  CNT_W  cycles with ControlMux=1 (saturates at all-ones)
//   FlushCount      out  CNT_W  accepted redirects (saturates at all-ones)
//   StallTimeout    out  1   sticky: stall lasted >= STALL_LIMIT consecutive cycles
// BEHAVIOUR
//   Reset (sync, highest priority): PC=RESET_PC, Instruction_ID=NOP_INSTR, PCPlus4_ID=0, Valid_ID=0,
//     counters=0, StallTimeout=0, FSM=RUN. Reset mid-stall/redirect discards all pending state.
//   Per-edge priority when not in Reset:
//     1. PCSTOP=1: PC holds; BranchTaken ignored (decode operands not ready, decision invalid).
//     2. else BranchTaken=1: PC<=BranchTarget; IF/ID <= {NOP_INSTR, 0, Valid=0} (flush of wrong-path
//        fetch, no delay slot); FlushCount++ (sat).
//     3. else: PC<=PC+4 (mod 2^32, wraps 32'hFFFF_FFFC->0); IF/ID loads {Instruction_IF, PC+4, Valid=1} if IDIF=1.
//   IF/ID update is independent of PC: IDIF=0 always holds IF/ID (except flush case 2, which
//     requires PCSTOP=0 and overrides IDIF). PCSTOP=1 with IDIF=1 is legal: PC holds, IF/ID reloads same word.
//   PC change visible on PC the cycle after the edge; latency fetch->Instruction_ID = 1 cycle.
//   FSM (stall watchdog), cnt = consecutive ControlMux cycles (saturates at STALL_LIMIT):
//     RUN     : ControlMux=1 -> STALLED, cnt=1; else stay.
//     STALLED : ControlMux=1 -> cnt++; cnt reaching STALL_LIMIT -> HUNG, set StallTimeout.
//               ControlMux=0 -> RUN, cnt=0.
//     HUNG    : StallTimeout stays 1; ControlMux=0 -> RUN. Only Reset clears StallTimeout.
//   StallCount increments on every edge with ControlMux=1 in any state; both counters hold at 2^CNT_W-1.
//   Same-cycle stall+redirect: stall wins, FlushCount unchanged, redirect must be re-presented by decode.
// TESTING
//   1 Reset 2 cycles, then free run with imem = word index: PC 0,4,8,..; Instruction_ID lags PC by 1 cycle; Valid_ID=1 after first fetch.
//   2 PCSTOP=1,IDIF=0,ControlMux=1 for 3 cycles at PC=0x10: PC stays 0x10, Instruction_ID frozen, StallCount=3; release -> PC=0x14 next edge.
//   3 BranchTaken=1, BranchTarget=0x40 at PC=0x20: next PC=0x40, Instruction_ID=NOP_INSTR, Valid_ID=0, FlushCount=1; following fetch valid.
//   4 BranchTaken=1 and PCSTOP=1 same cycle: PC holds, no flush, FlushCount unchanged.
//   5 ControlMux=1 for 8 cycles: StallTimeout rises on 8th edge, stays 1 after release, cleared only by Reset.
//   6 CNT_W=4: 20 stall cycles -> StallCount=15; PC=0xFFFF_FFFC free-run -> PC=0x0; Reset mid-stall -> all outputs to reset values next edge.

Source files
------------

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side stall consumer: owns the PC and the IF/ID register, applies holds, redirects and bubbles.
// Latency: PC and IF/ID update on the edge and are visible the next cycle; fetch->Instruction_ID is 1 cycle.
// Backpressure: PCSTOP holds the PC, IDIF=0 holds IF/ID; a redirect under PCSTOP is dropped and must be re-presented.
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCSTOP,
    input  logic             IDIF,
    input  logic             ControlMux,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      Instruction_IF,
    output logic [31:0]      PC,
    output logic [31:0]      Instruction_ID,
    output logic [31:0]      PCPlus4_ID,
    output logic             Valid_ID,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             StallTimeout
);

    // Run-length counter only needs to reach STALL_LIMIT, where it saturates.
    localparam int unsigned RC_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RC_W-1:0] LIMIT = RC_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALLED = 2'd1,
        ST_HUNG    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   run_cnt_q, run_cnt_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_id_q, instr_id_d;
    logic [31:0]       pcp4_id_q, pcp4_id_d;
    logic              valid_id_q, valid_id_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [31:0]       pc_plus4;
    logic              redirect;
    logic [RC_W-1:0]   run_inc;

    assign pc_plus4 = pc_q + 32'd4;
    // A redirect decided while PC is held is based on stale operands, so it is ignored.
    assign redirect = BranchTaken && !PCSTOP;
    assign run_inc  = run_cnt_q + RC_W'(1);

    // PC, IF/ID and event counters: flush beats IDIF, hold beats redirect.
    always_comb begin
        pc_d        = pc_q;
        instr_id_d  = instr_id_q;
        pcp4_id_d   = pcp4_id_q;
        valid_id_d  = valid_id_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (redirect) begin
            pc_d       = BranchTarget;
            instr_id_d = NOP_INSTR;
            pcp4_id_d  = 32'd0;
            valid_id_d = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else begin
            if (!PCSTOP) begin
                pc_d = pc_plus4;
            end
            if (IDIF) begin
                instr_id_d = Instruction_IF;
                pcp4_id_d  = pc_plus4;
                valid_id_d = 1'b1;
            end
        end

        if (ControlMux && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall watchdog: tracks consecutive ControlMux cycles and latches a sticky timeout.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_RUN: begin
                if (ControlMux) begin
                    run_cnt_d = RC_W'(1);
                    if (LIMIT <= RC_W'(1)) begin
                        state_d   = ST_HUNG;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_STALLED;
                    end
                end
            end
            ST_STALLED: begin
                if (ControlMux) begin
                    if (run_inc >= LIMIT) begin
                        run_cnt_d = LIMIT;
                        state_d   = ST_HUNG;
                        timeout_d = 1'b1;
                    end else begin
                        run_cnt_d = run_inc;
                    end
                end else begin
                    run_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_HUNG: begin
                if (!ControlMux) begin
                    run_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                run_cnt_d = '0;
                state_d   = ST_RUN;
            end
        endcase
    end

    // State register; Reset discards any pending stall or redirect state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            run_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            pc_q        <= RESET_PC;
            instr_id_q  <= NOP_INSTR;
            pcp4_id_q   <= 32'd0;
            valid_id_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            timeout_q   <= timeout_d;
            pc_q        <= pc_d;
            instr_id_q  <= instr_id_d;
            pcp4_id_q   <= pcp4_id_d;
            valid_id_q  <= valid_id_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC             = pc_q;
    assign Instruction_ID = instr_id_q;
    assign PCPlus4_ID     = pcp4_id_q;
    assign Valid_ID       = valid_id_q;
    assign StallCount     = stall_cnt_q;
    assign FlushCount     = flush_cnt_q;
    assign StallTimeout   = timeout_q;

endmodule
